// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and helpers for the seven-segment scan controller
package seg_pkg;

  localparam int SEG_W = 7;

  // Active-high segment patterns for hex digits 0..F, bit0 = segment a
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // All segments dark, in active-high terms
  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  // Convert an active-high segment vector to pin polarity
  function automatic logic [SEG_W-1:0] seg_pol(input logic [SEG_W-1:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_seg_decode.sv
// rtl/seg_scan_ctrl_hex_seg_decode.sv - hex nibble to active-high seven-segment decoder
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segs
);

  // Pure table lookup; polarity is applied later at the pin register
  assign segs = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with PWM, blink and blanking
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  display_clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SH_W  = 5 * DIGITS;

  localparam logic                pol_low     = (ACTIVE_LOW != 0);
  localparam logic [PWM_BITS-1:0] PWM_MAX     = '1;
  localparam logic [DIG_W-1:0]    DIG_LAST    = DIG_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST    = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0]   AN_OFF      = pol_low ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [SEG_W-1:0]    SEG_PIN_OFF = seg_pol(SEG_OFF, pol_low);
  localparam logic                DP_OFF      = pol_low;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIG_W-1:0]    dig_idx;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic [SH_W-1:0]     shadow;
  logic [SH_W-1:0]     active;

  logic                  pwm_wrap;
  logic                  frame_wrap;
  logic [4*DIGITS-1:0]   active_val;
  logic [DIGITS-1:0]     active_dp;
  logic [DIGITS-1:0]     lz_blank;
  logic                  zero_above;
  logic [3:0]            cur_nib;
  logic                  lit;
  logic [DIGITS-1:0]     an_onehot;
  logic [SEG_W-1:0]      dec_seg;

  assign pwm_wrap   = (pwm_cnt == PWM_MAX);
  assign frame_wrap = pwm_wrap && (dig_idx == DIG_LAST);
  assign active_val = active[SH_W-1:DIGITS];
  assign active_dp  = active[DIGITS-1:0];
  assign cur_nib    = active_val[{dig_idx, 2'b00} +: 4];

  // Leading-zero mask: a digit blanks when it and every more significant nibble is zero; digit 0 never blanks
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (active_val[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz && zero_above;
    end
  end

  // Lit decision for the digit currently addressed by the scan counters
  always_comb begin
    lit = (pwm_cnt <= brightness)
          && !(blink_mask[dig_idx] && blink_phase)
          && !lz_blank[dig_idx];
    an_onehot = lit ? (DIGITS'(1) << dig_idx) : '0;
  end

  hex_seg_decode u_decode (
    .nibble (cur_nib),
    .segs   (dec_seg)
  );

  // PWM sub-slot and digit scan counters
  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      dig_idx <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_wrap) begin
        dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
      end
    end
  end

  // Blink frame counter and phase, advanced once per full scan
  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Shadow capture on load; active only follows shadow at frame boundaries so no frame is ever mixed
  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      active     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow <= {value, dp_in};
      end
      if (frame_wrap) begin
        active <= shadow;
      end
      frame_done <= frame_wrap;
    end
  end

  // Pin registers: everything dark when unlit to avoid ghosting, polarity applied here
  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_PIN_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= lit ? seg_pol(dec_seg, pol_low) : SEG_PIN_OFF;
      dp  <= (lit && active_dp[dig_idx]) ^ DP_OFF;
      an  <= an_onehot ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        display_clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [2:0]  brightness;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_hi [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 display_clk = ~display_clk;

  seg_scan_ctrl #(
    .DIGITS       (4),
    .PWM_BITS     (3),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .display_clk (display_clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .brightness  (brightness),
    .blink_mask  (blink_mask),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    return ~hex_hi[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge display_clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge display_clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called on the negedge where frame_done is high; checks the 32 cycles of the frame that follows
  task automatic scan_frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                            input logic [3:0] blanked, input int bright);
    int         d;
    bit         on;
    logic [3:0] one;
    for (int k = 0; k < 32; k++) begin
      @(negedge display_clk);
      d   = k / 8;
      on  = ((k % 8) <= bright) && !blanked[d];
      one = 4'b0001 << d;
      check({tag, "_an"},  {28'd0, an},  on ? {28'd0, ~one} : 32'hF);
      check({tag, "_seg"}, {25'd0, seg}, on ? {25'd0, exp_seg(v[4*d +: 4])} : 32'h7F);
      check({tag, "_dp"},  {31'd0, dp},  on ? {31'd0, ~dpv[d]} : 32'd1);
      check({tag, "_fd"},  {31'd0, frame_done}, (k == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    value      = 16'h0000;
    dp_in      = 4'h0;
    load       = 1'b0;
    brightness = 3'd7;
    blink_mask = 4'h0;
    blank_lz   = 1'b0;

    #12;
    check("rst_an",  {28'd0, an},  32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp",  {31'd0, dp},  32'd1);
    check("rst_fd",  {31'd0, frame_done}, 32'd0);

    @(negedge display_clk);
    reset = 1'b0;

    // Full brightness, 1234
    @(negedge display_clk);
    pulse_load(16'h1234, 4'h0);
    wait_frame();
    scan_frame("v1234", 16'h1234, 4'h0, 4'h0, 7);
    scan_frame("v1234b", 16'h1234, 4'h0, 4'h0, 7);

    // Reduced brightness: 3 of 8 sub-slots lit
    brightness = 3'd2;
    pulse_load(16'h000F, 4'h0);
    wait_frame();
    scan_frame("pwm2", 16'h000F, 4'h0, 4'h0, 2);

    // Leading-zero blanking, dp suppressed on blanked digits
    brightness = 3'd7;
    blank_lz   = 1'b1;
    pulse_load(16'h0050, 4'hF);
    wait_frame();
    scan_frame("lz0050", 16'h0050, 4'hF, 4'b1100, 7);
    pulse_load(16'h0000, 4'hF);
    wait_frame();
    scan_frame("lz0000", 16'h0000, 4'hF, 4'b1110, 7);

    // Load coinciding with the frame-wrap cycle
    blank_lz = 1'b0;
    pulse_load(16'h1234, 4'h0);
    wait_frame();
    repeat (31) @(negedge display_clk);
    value = 16'hABCD;
    load  = 1'b1;
    @(negedge display_clk);
    load  = 1'b0;
    check("wrap_fd", {31'd0, frame_done}, 32'd1);
    scan_frame("wrap_old", 16'h1234, 4'h0, 4'h0, 7);
    scan_frame("wrap_new", 16'hABCD, 4'h0, 4'h0, 7);

    // Reset mid-slot at pwm_cnt=5, dig_idx=2
    repeat (21) @(negedge display_clk);
    check("pre_rst_an",  {28'd0, an},  32'hB);
    check("pre_rst_seg", {25'd0, seg}, {25'd0, exp_seg(4'hB)});
    reset = 1'b1;
    #1;
    check("async_an",  {28'd0, an},  32'hF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_dp",  {31'd0, dp},  32'd1);
    blink_mask = 4'b0001;
    @(negedge display_clk);
    check("held_an", {28'd0, an}, 32'hF);
    reset = 1'b0;

    // Restart from digit 0 with active cleared, then blink digit 0 every two frames
    for (int n = 1; n <= 192; n++) begin
      int c;
      int f;
      int s;
      @(negedge display_clk);
      c = n - 1;
      f = c / 32;
      s = c % 32;
      if (n == 1) begin
        check("restart_an",  {28'd0, an},  32'hE);
        check("restart_seg", {25'd0, seg}, 32'h40);
      end
      if (s == 3)  check("blink_d0", {28'd0, an}, (((f / 2) % 2) == 0) ? 32'hE : 32'hF);
      if (s == 11) check("blink_d1", {28'd0, an}, 32'hD);
      if (s == 31) check("blink_fd", {31'd0, frame_done}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
